// File: rtl/dmem_wbuf.sv
// Data-memory responder with a posted write buffer: stores queue up and drain into
// the asynchronous-read array one per cycle, and loads forward from the youngest queued store.
module dmem_wbuf #(
    parameter int n      = 16,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   memwrite,
    input  logic [n-1:0]           addr,
    input  logic [n-1:0]           writedata,
    output logic [n-1:0]           readdata,
    input  logic                   drain_hold,
    output logic                   stall,
    output logic [$clog2(DEPTH):0] wb_count,
    output logic                   wb_empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] ZERO_CNT = {CW{1'b0}};
    localparam logic [CW-1:0] ONE_CNT  = CW'(1'b1);
    localparam logic [PW-1:0] ONE_PTR  = PW'(1'b1);

    logic [n-1:0]      mem_r [2**ADDR_W];
    logic [ADDR_W-1:0] ent_addr_r [DEPTH];
    logic [n-1:0]      ent_data_r [DEPTH];
    logic [DEPTH-1:0]  valid_r;
    logic [DEPTH-1:0]  valid_s;
    logic [PW-1:0]     head_r;
    logic [PW-1:0]     tail_r;
    logic [CW-1:0]     count_r;
    logic [CW-1:0]     count_s;
    logic              empty_r;
    logic [ADDR_W-1:0] word_s;
    logic              full_s;
    logic              enq_s;
    logic              drain_s;
    logic [n-1:0]      rd_s;
    logic              unused_addr_s;

    assign word_s        = addr[ADDR_W-1:0];
    assign unused_addr_s = ^addr[n-1:ADDR_W];
    assign full_s        = (count_r == FULL_CNT);
    assign enq_s         = memwrite && !full_s;
    assign drain_s       = (count_r != ZERO_CNT) && !drain_hold;
    // Full is judged on the pre-edge count, so a slot freed by this edge's drain is not reused yet.
    assign stall         = reset && memwrite && full_s;
    assign readdata      = rd_s;
    assign wb_count      = count_r;
    assign wb_empty      = empty_r;

    // Occupancy and entry-valid bookkeeping for this cycle's enqueue/drain pair.
    always_comb begin
        count_s = count_r;
        valid_s = valid_r;
        case ({enq_s, drain_s})
            2'b10:   count_s = count_r + ONE_CNT;
            2'b01:   count_s = count_r - ONE_CNT;
            default: count_s = count_r;
        endcase
        if (drain_s) begin
            valid_s[head_r] = 1'b0;
        end else begin
            valid_s[head_r] = valid_r[head_r];
        end
        if (enq_s) begin
            valid_s[tail_r] = 1'b1;
        end else begin
            valid_s[tail_r] = valid_s[tail_r];
        end
    end

    // Buffer control registers; reset discards anything still queued.
    always_ff @(posedge clk) begin
        if (!reset) begin
            head_r  <= {PW{1'b0}};
            tail_r  <= {PW{1'b0}};
            valid_r <= {DEPTH{1'b0}};
            count_r <= ZERO_CNT;
            empty_r <= 1'b1;
        end else begin
            if (enq_s) begin
                tail_r <= tail_r + ONE_PTR;
            end
            if (drain_s) begin
                head_r <= head_r + ONE_PTR;
            end
            valid_r <= valid_s;
            count_r <= count_s;
            empty_r <= (count_s == ZERO_CNT);
        end
    end

    // Capture an accepted store into the tail slot.
    always_ff @(posedge clk) begin
        if (reset && enq_s) begin
            ent_addr_r[tail_r] <= word_s;
            ent_data_r[tail_r] <= writedata;
        end
    end

    // Retire the head entry into the array.
    always_ff @(posedge clk) begin
        if (reset && drain_s) begin
            mem_r[ent_addr_r[head_r]] <= ent_data_r[head_r];
        end
    end

    // Oldest-to-youngest scan so the last match (youngest store) wins over the array.
    always_comb begin
        rd_s = mem_r[word_s];
        for (int unsigned i = 32'd0; i < 32'(DEPTH); i++) begin
            if (valid_r[head_r + PW'(i)] && (ent_addr_r[head_r + PW'(i)] == word_s)) begin
                rd_s = ent_data_r[head_r + PW'(i)];
            end else begin
                rd_s = rd_s;
            end
        end
    end
endmodule

// File: tb/tb_dmem_wbuf.sv
// Directed bench for dmem_wbuf: a queue-based memory model checked every cycle,
// plus hand-computed expectations at the key points of each scenario.
module tb_dmem_wbuf;
    localparam int DEPTH = 4;

    logic        clk;
    logic        reset;
    logic        memwrite;
    logic [15:0] addr;
    logic [15:0] writedata;
    logic [15:0] readdata;
    logic        drain_hold;
    logic        stall;
    logic [2:0]  wb_count;
    logic        wb_empty;

    dmem_wbuf #(.n(16), .ADDR_W(8), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .memwrite(memwrite), .addr(addr),
        .writedata(writedata), .readdata(readdata), .drain_hold(drain_hold),
        .stall(stall), .wb_count(wb_count), .wb_empty(wb_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  a;
        logic [15:0] d;
    } ent_t;

    ent_t        mq[$];
    logic [15:0] mmem [256];
    bit          mknown [256];
    ent_t        m_e;
    bit          m_enq;
    bit          m_drain;
    bit          chk_en = 1'b0;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] ev;
    bit          ev_ok;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Youngest queued store to the word wins; otherwise the array, if the model knows it.
    function automatic void model_rd(input logic [15:0] a, output logic [15:0] v, output bit ok);
        ok = 1'b0;
        v  = 16'h0000;
        for (int i = mq.size() - 1; i >= 0; i--) begin
            if (mq[i].a == a[7:0]) begin
                v  = mq[i].d;
                ok = 1'b1;
                break;
            end
        end
        if (!ok && mknown[a[7:0]]) begin
            v  = mmem[a[7:0]];
            ok = 1'b1;
        end
    endfunction

    always @(posedge clk) begin
        if (!reset) begin
            mq.delete();
        end else begin
            m_enq   = memwrite && (mq.size() < DEPTH);
            m_drain = (mq.size() > 0) && !drain_hold;
            if (m_drain) begin
                m_e = mq.pop_front();
                mmem[m_e.a]   = m_e.d;
                mknown[m_e.a] = 1'b1;
            end
            if (m_enq) begin
                m_e.a = addr[7:0];
                m_e.d = writedata;
                mq.push_back(m_e);
            end
        end
    end

    always @(negedge clk) begin
        #2;
        if (chk_en) begin
            chk("stall", {31'd0, stall}, {31'd0, reset && memwrite && (mq.size() == DEPTH)});
            chk("wb_count", {29'd0, wb_count}, mq.size());
            chk("wb_empty", {31'd0, wb_empty}, {31'd0, mq.size() == 0});
            model_rd(addr, ev, ev_ok);
            if (ev_ok) chk("readdata", {16'd0, readdata}, {16'd0, ev});
        end
    end

    task automatic step(input logic mw, input logic [15:0] a, input logic [15:0] d, input logic hold);
        @(negedge clk);
        reset      = 1'b1;
        memwrite   = mw;
        addr       = a;
        writedata  = d;
        drain_hold = hold;
        #3;
    endtask

    task automatic rst_cycle();
        @(negedge clk);
        reset    = 1'b0;
        memwrite = 1'b0;
        #3;
    endtask

    int k;
    int stalls;
    int iter;

    initial begin
        reset = 1'b0; memwrite = 1'b0; addr = 16'h0000; writedata = 16'h0000; drain_hold = 1'b0;
        chk_en = 1'b1;
        rst_cycle();
        step(1'b0, 16'd0, 16'h0000, 1'b0);
        chk("rst_count", {29'd0, wb_count}, 32'd0);
        chk("rst_empty", {31'd0, wb_empty}, 32'd1);
        chk("rst_stall", {31'd0, stall}, 32'd0);

        // 1: store then forwarded load, then committed
        step(1'b1, 16'd5, 16'h1234, 1'b0);
        step(1'b0, 16'd5, 16'h0000, 1'b0);
        chk("t1_fwd_rd", {16'd0, readdata}, 32'h1234);
        chk("t1_fwd_count", {29'd0, wb_count}, 32'd1);
        step(1'b0, 16'd5, 16'h0000, 1'b0);
        chk("t1_arr_rd", {16'd0, readdata}, 32'h1234);
        chk("t1_arr_empty", {31'd0, wb_empty}, 32'd1);

        // 2: fill with hold, stall on full, release
        for (int i = 0; i < 4; i++) step(1'b1, 16'(i), 16'h00A0 + 16'(i), 1'b1);
        step(1'b1, 16'd4, 16'h0044, 1'b1);
        chk("t2_stall_full", {31'd0, stall}, 32'd1);
        chk("t2_count_full", {29'd0, wb_count}, 32'd4);
        step(1'b1, 16'd4, 16'h0044, 1'b0);
        chk("t2_stall_release", {31'd0, stall}, 32'd1);
        step(1'b1, 16'd4, 16'h0044, 1'b0);
        chk("t2_accept", {31'd0, stall}, 32'd0);
        chk("t2_count3", {29'd0, wb_count}, 32'd3);
        step(1'b0, 16'd4, 16'h0000, 1'b0);
        chk("t2_fwd4", {16'd0, readdata}, 32'h0044);
        repeat (4) step(1'b0, 16'd0, 16'h0000, 1'b0);

        // 3: two stores to one word, youngest wins
        step(1'b1, 16'd7, 16'hAAAA, 1'b1);
        step(1'b1, 16'd7, 16'hBBBB, 1'b1);
        step(1'b0, 16'd7, 16'h0000, 1'b1);
        chk("t3_youngest", {16'd0, readdata}, 32'hBBBB);
        chk("t3_count", {29'd0, wb_count}, 32'd2);
        step(1'b0, 16'd7, 16'h0000, 1'b0);
        step(1'b0, 16'd7, 16'h0000, 1'b0);
        step(1'b0, 16'd7, 16'h0000, 1'b0);
        chk("t3_array", {16'd0, readdata}, 32'hBBBB);

        // 4: reset discards undrained stores
        for (int i = 1; i < 4; i++) step(1'b1, 16'(i), 16'hD000 + 16'(i), 1'b1);
        rst_cycle();
        step(1'b0, 16'd1, 16'h0000, 1'b1);
        chk("t4_count", {29'd0, wb_count}, 32'd0);
        chk("t4_empty", {31'd0, wb_empty}, 32'd1);
        chk("t4_arr1", {16'd0, readdata}, 32'h00A1);
        step(1'b0, 16'd3, 16'h0000, 1'b1);
        chk("t4_arr3", {16'd0, readdata}, 32'h00A3);

        // 5: full buffer, back-to-back stores with wrap
        for (int i = 0; i < 4; i++) step(1'b1, 16'd30 + 16'(i), 16'h3000 + 16'(i), 1'b1);
        k = 0; stalls = 0; iter = 0;
        while (k < 10 && iter < 40) begin
            step(1'b1, 16'd10 + 16'(k), 16'h5000 + 16'(k), 1'b0);
            iter++;
            if (stall) stalls++;
            else k++;
        end
        chk("t5_accepted", k, 32'd10);
        chk("t5_stalls", stalls, 32'd1);
        repeat (6) step(1'b0, 16'd0, 16'h0000, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 16'd10 + 16'(i), 16'h0000, 1'b0);
            chk("t5_arr", {16'd0, readdata}, 32'h5000 + i);
        end
        step(1'b0, 16'd33, 16'h0000, 1'b0);
        chk("t5_arr33", {16'd0, readdata}, 32'h3003);

        // 6: load misses buffer, stall quiet without memwrite, upper address bits ignored
        step(1'b1, 16'd200, 16'hC8C8, 1'b0);
        step(1'b0, 16'd0, 16'h0000, 1'b0);
        for (int i = 1; i < 5; i++) step(1'b1, 16'd200 + 16'(i), 16'hC900 + 16'(i), 1'b1);
        step(1'b0, 16'd200, 16'h0000, 1'b1);
        chk("t6_miss_rd", {16'd0, readdata}, 32'hC8C8);
        chk("t6_no_stall", {31'd0, stall}, 32'd0);
        chk("t6_count", {29'd0, wb_count}, 32'd4);
        step(1'b0, 16'h0000 + 16'd204, 16'h0000, 1'b1);
        chk("t6_fwd204", {16'd0, readdata}, 32'hC904);
        step(1'b0, 16'hFF05, 16'h0000, 1'b0);
        chk("t6_upper_ignored", {16'd0, readdata}, 32'h1234);
        repeat (5) step(1'b0, 16'd0, 16'h0000, 1'b0);
        chk("t6_drained", {31'd0, wb_empty}, 32'd1);

        @(negedge clk);
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
